// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
// Holds the FSM encoding, word geometry and the partial-word byte-enable helper.
package loader_pkg;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } state_e;

  // Byte enables for a word holding the first n bytes (n = 1..4).
  function automatic logic [LANES-1:0] lane_mask(input logic [2:0] n);
    case (n)
      3'd0:    lane_mask = 4'b0000;
      3'd1:    lane_mask = 4'b0001;
      3'd2:    lane_mask = 4'b0011;
      3'd3:    lane_mask = 4'b0111;
      default: lane_mask = 4'b1111;
    endcase
  endfunction
endpackage

// File: rtl/instr_mem_loader_if.sv
// Host stream, instruction-memory write port and status signals of the loader.
// The host/bench drives through master; the loader sits on slave.
interface instr_mem_loader_if #(parameter int ADDR_W = 10) ();
  logic                          start;
  logic [ADDR_W:0]               len;
  logic                          in_valid;
  logic [7:0]                    in_data;
  logic                          in_ready;
  logic                          mem_we;
  logic [ADDR_W-3:0]             mem_addr;
  logic [loader_pkg::WORD_W-1:0] mem_wdata;
  logic [loader_pkg::LANES-1:0]  mem_be;
  logic                          cpu_hold;
  logic                          busy;
  logic                          done;
  logic                          err;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata, mem_be, cpu_hold, busy, done, err
  );
  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata, mem_be, cpu_hold, busy, done, err
  );
endinterface

// File: rtl/instr_mem_loader_packer.sv
// Packs accepted bytes into 32-bit little-endian words and registers the write.
// A flush emits the word one cycle after the accepting edge, then clears the lanes.
module lm_word_packer
  import loader_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    accept_i,
  input  logic                    flush_i,
  input  logic [1:0]              lane_i,
  input  logic [7:0]              data_i,
  input  logic [AW-1:0]           waddr_i,
  output logic                    mem_we_o,
  output logic [AW-1:0]           mem_addr_o,
  output logic [WORD_W-1:0]       mem_wdata_o,
  output logic [LANES-1:0]        mem_be_o
);
  logic [LANES-1:0][7:0] lanes_q, lanes_d;
  logic                  we_q;
  logic [AW-1:0]         addr_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [LANES-1:0]      be_q;

  always_comb begin
    lanes_d = lanes_q;
    if (accept_i) lanes_d[lane_i] = data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lanes_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (clear_i) begin
        lanes_q <= '0;
      end else if (accept_i) begin
        if (flush_i) begin
          we_q    <= 1'b1;
          addr_q  <= waddr_i;
          wdata_q <= lanes_d;
          // bytes arrive in lane order, so lane_i+1 lanes are filled
          be_q    <= lane_mask({1'b0, lane_i} + 3'd1);
          lanes_q <= '0;
        end else begin
          lanes_q <= lanes_d;
        end
      end
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;
endmodule

// File: rtl/instr_mem_loader.sv
// Runtime instruction-memory loader: FSM, byte counter, length check and checksum.
// Keeps the CPU in reset until a load ends with a good checksum.
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  instr_mem_loader_if.slave   bus
);
  localparam int MEM_BYTES = 1 << ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        sum_chk;
  logic              in_ready, fire, last, accept, flush, clear;
  logic [WORD_W-1:0] wdata_w;

  assign in_ready = (state_q == LOAD) | (state_q == CHECK);
  assign fire     = bus.in_valid & in_ready;
  assign last     = ({1'b0, cnt_q} == (len_q - 1'b1));
  assign accept   = fire & (state_q == LOAD);
  assign flush    = accept & ((cnt_q[1:0] == 2'd3) | last);
  assign sum_chk  = sum_q + bus.in_data;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum_d   = sum_q;
    clear   = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          clear = 1'b1;
          cnt_d = '0;
          sum_d = '0;
          len_d = bus.len;
          if (bus.len > MEM_BYTES[ADDR_W:0]) state_d = ERR;
          else if (bus.len == '0)            state_d = CHECK;
          else                               state_d = LOAD;
        end
      end
      LOAD: begin
        if (fire) begin
          cnt_d = cnt_q + 1'b1;
          sum_d = sum_chk;
          if (last) state_d = CHECK;
        end
      end
      CHECK: begin
        if (fire) state_d = (sum_chk == 8'd0) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
    end
  end

  lm_word_packer #(.AW(ADDR_W-2)) u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (clear),
    .accept_i    (accept),
    .flush_i     (flush),
    .lane_i      (cnt_q[1:0]),
    .data_i      (bus.in_data),
    .waddr_i     (cnt_q[ADDR_W-1:2]),
    .mem_we_o    (bus.mem_we),
    .mem_addr_o  (bus.mem_addr),
    .mem_wdata_o (wdata_w),
    .mem_be_o    (bus.mem_be)
  );

  assign bus.mem_wdata = wdata_w;
  assign bus.in_ready  = in_ready;
  assign bus.busy      = in_ready;
  assign bus.done      = (state_q == DONE);
  assign bus.err       = (state_q == ERR);
  assign bus.cpu_hold  = (state_q != DONE);
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: expected writes queue up as bytes are
// planned and are popped by a monitor whenever mem_we fires.
module tb_instr_mem_loader;
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic clk, rst;
  int   total = 0, bad = 0;
  wr_t  sb[$];
  wr_t  mon_e;
  logic [7:0] buf_b [0:1023];

  instr_mem_loader_if #(.ADDR_W(10)) bus ();
  instr_mem_loader #(.ADDR_W(10), .WORD_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_write addr=%0h data=%0h be=%0h", bus.mem_addr, bus.mem_wdata, bus.mem_be);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        total++;
        assert ({bus.mem_addr, bus.mem_wdata, bus.mem_be} === {mon_e.addr, mon_e.data, mon_e.be}) else begin
          bad++;
          $error("FAIL write observed=%0h/%0h/%0h expected=%0h/%0h/%0h", bus.mem_addr, bus.mem_wdata,
                 bus.mem_be, mon_e.addr, mon_e.data, mon_e.be);
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_mem_we"},   64'(bus.mem_we),   64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_wdata"},    64'(bus.mem_wdata), 64'd0);
    chk({tag, "_be"},       64'(bus.mem_be),   64'd0);
    chk({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'd1);
    chk({tag, "_busy"},     64'(bus.busy),     64'd0);
    chk({tag, "_done"},     64'(bus.done),     64'd0);
    chk({tag, "_err"},      64'(bus.err),      64'd0);
  endtask

  task automatic start_load(input int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 11'(n);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (bus.in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("ready_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Full load: queue expected writes, stream bytes, send checksum, check status.
  task automatic do_load(input string tag, input int n, input bit cs_ok, input int gap_after,
                         input int start_at);
    wr_t w;
    logic [7:0] sum = 8'd0;
    for (int wi = 0; wi < (n + 3) / 4; wi++) begin
      w.addr = 8'(wi);
      w.data = '0;
      w.be   = '0;
      for (int l = 0; l < 4; l++) begin
        if (4 * wi + l < n) begin
          w.data[8*l +: 8] = buf_b[4*wi+l];
          w.be[l] = 1'b1;
        end
      end
      sb.push_back(w);
    end
    start_load(n);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
    for (int i = 0; i < n; i++) begin
      if (i == start_at) begin
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = 11'd4;
        @(negedge clk);
        bus.start = 1'b0;
      end
      send_byte(buf_b[i]);
      sum = sum + buf_b[i];
      if (i == gap_after) repeat (2) @(negedge clk);
    end
    send_byte(cs_ok ? 8'(-sum) : 8'(8'h5A - sum));
    repeat (2) @(negedge clk);
    chk({tag, "_done"},     64'(bus.done),     64'(cs_ok));
    chk({tag, "_err"},      64'(bus.err),      64'(!cs_ok));
    chk({tag, "_cpu_hold"}, 64'(bus.cpu_hold), 64'(!cs_ok));
    chk({tag, "_busy_end"}, 64'(bus.busy),     64'd0);
    chk({tag, "_sb_empty"}, 64'(sb.size()),    64'd0);
    sb.delete();
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.len      = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // addiu $8,$0,1 with good checksum 0xD3
    buf_b[0] = 8'h01; buf_b[1] = 8'h00; buf_b[2] = 8'h08; buf_b[3] = 8'h24;
    do_load("addiu", 4, 1'b1, -1, -1);

    // six bytes with a stall after the second byte, partial second word
    for (int i = 0; i < 6; i++) buf_b[i] = 8'((i + 1) * 8'h11);
    do_load("len6_gap", 6, 1'b1, 1, -1);

    // bad checksum from DONE re-start
    buf_b[0] = 8'h01; buf_b[1] = 8'h00; buf_b[2] = 8'h08; buf_b[3] = 8'h24;
    do_load("bad_cs", 4, 1'b0, -1, -1);

    // oversize length: immediate error, no stream accepted
    start_load(1025);
    chk("oversize_err", 64'(bus.err), 64'd1);
    chk("oversize_ready", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("oversize_ready_late", 64'(bus.in_ready), 64'd0);
    chk("oversize_hold", 64'(bus.cpu_hold), 64'd1);
    bus.in_valid = 1'b0;

    // reset in the middle of a load
    for (int i = 0; i < 8; i++) buf_b[i] = 8'(8'hA0 + i);
    start_load(8);
    send_byte(buf_b[0]);
    send_byte(buf_b[1]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    buf_b[0] = 8'h01; buf_b[1] = 8'h00; buf_b[2] = 8'h08; buf_b[3] = 8'h24;
    do_load("after_rst", 4, 1'b1, -1, -1);

    // start pulse during LOAD is ignored
    for (int i = 0; i < 8; i++) buf_b[i] = 8'(8'h30 + 7 * i);
    do_load("start_in_load", 8, 1'b1, -1, 3);

    // boundaries: single byte, empty payload, full memory
    buf_b[0] = 8'hC5;
    do_load("len1", 1, 1'b1, -1, -1);
    do_load("len0", 0, 1'b1, -1, -1);
    for (int i = 0; i < 1024; i++) buf_b[i] = 8'($urandom_range(0, 255));
    do_load("len1024", 1024, 1'b1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
